cond_unit: RTL and testbench
============================

# cond_unit

Conditional-execution unit that sits directly downstream of the ALU in the multi-cycle datapath. It holds the architectural NZCV flag register, loaded from the ALU's 4-bit flag output. It evaluates the instruction's 4-bit condition field once per instruction at decode, and registers the pass/fail result for the remaining cycles of that instruction. It gates the controller's PC, register-file and memory write enables, and keeps a saturating count of condition-failed (skipped) instructions for debug.

## Interface
- CNT_W, 16, width of the skipped-instruction counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- Cond  in  4  instruction condition field [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- CondLatch  in  1  decode strobe; evaluate Cond and register the result
- FlagW  in  2  [1] = write N,Z; [0] = write C,V (controller, execute cycle)
- PCS  in  1  instruction writes PC (branch or Rd=R15)
- NextPC  in  1  fetch-phase PC increment, unconditional
- RegW  in  1  controller register-file write request
- MemW  in  1  controller memory write request
- NoWrite  in  1  compare-type instruction; suppress the register write
- PCWrite  out  1  gated PC enable
- RegWrite  out  1  gated register-file enable
- MemWrite  out  1  gated memory enable
- CondEx  out  1  registered condition result for the current instruction
- Flags  out  4  current {N,Z,C,V} register
- SkipCount  out  CNT_W  condition-failed instruction count, saturating

## Operation
- Condition decode uses the evaluation flags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 is treated as always (1)
- CondLatch=1: the condition result is written into the CondEx register. If the result is 0, SkipCount increments by 1, holding at all-ones.
- CondLatch=0: CondEx holds its value.
- Flag write:
  - Flags[3:2] load ALUFlags[3:2] when FlagW[1]&CondEx.
  - Flags[1:0] load ALUFlags[1:0] when FlagW[0]&CondEx.
  - Otherwise the flags hold.
- Combinational outputs:
  - PCWrite = (PCS&CondEx) | NextPC
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
- While reset=0, PCWrite, RegWrite and MemWrite are forced to 0.
- Reset values: Flags=0000, CondEx=0, SkipCount=0.

## Timing
- CondEx is valid from the cycle after the CondLatch edge. It is stable until the next CondLatch.
- Flags reflect a write on the cycle after the FlagW edge. Flag-write latency is 1 cycle.
- FlagW in the same cycle as CondLatch is qualified by the old CondEx, not the newly evaluated one. The controller must not do this; the bench checks that the unit behaves as stated.
- Gated write enables are combinational from the inputs and CondEx, with 0-cycle latency.
- SkipCount at all-ones stays all-ones on further fails. It does not wrap.
- Reset low mid-instruction: on the next edge all state clears. A pending CondEx=1 is lost, so the following instruction's writes are suppressed until the next CondLatch.

## Configuration
- COND_FLAG_BYPASS_EN defined:
  - When CondLatch and a qualifying FlagW occur in the same cycle, the evaluation flags are the next-flag value: ALUFlags merged per FlagW bit.
  - This allows back-to-back flag-set then conditional issue.
- COND_FLAG_BYPASS_EN undefined: the evaluation flags are always the registered Flags. Same-cycle writes are invisible to the evaluation.

## Test plan
- Reset (reset=0 for 2 cycles, RegW=MemW=PCS=1) -> Flags=0000, CondEx=0, SkipCount=0, all write enables 0 during reset.
- CondLatch with Cond=1110, then FlagW=11 with ALUFlags=0100 -> CondEx=1 next cycle; Flags=0100 one cycle after the write; RegW=1 gives RegWrite=1.
- Flags=0100, CondLatch with Cond=0001 (NE) -> CondEx=0, SkipCount=1. RegW=MemW=PCS=1 gives all enables 0; additionally asserting NextPC=1 gives PCWrite=1.
- Flags=1001 (N=1, V=1), sweep GE/LT/GT/LE -> CondEx results 1/0/1/0. With Flags=1000: GE/LT/GT/LE give 0/1/0/1.
- FlagW=01 with ALUFlags=1111 over Flags=0000, CondEx=1 -> Flags=0011; NoWrite=1 with RegW=1 gives RegWrite=0.
- Preload SkipCount to 16'hFFFE with fails, then 3 more CondLatch fails -> SkipCount=16'hFFFF and holds.
- With COND_FLAG_BYPASS_EN, same-cycle EQ latch plus a Z write:
  - Setup: Flags=0000, CondEx=1, ALUFlags=0100, FlagW=10, CondLatch with Cond=0000 (EQ) in the same cycle.
  - Macro defined -> CondEx=1.
  - Macro undefined -> CondEx=0.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, per-instruction condition evaluation,
// write-enable gating and a saturating count of skipped instructions.
//
// Parameters:
//   CNT_W      width of SkipCount
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   Cond       instruction condition field
//   ALUFlags   {N,Z,C,V} from the ALU
//   CondLatch  decode strobe, registers the condition result
//   FlagW      [1] write N,Z  [0] write C,V
//   PCS        instruction writes the PC
//   NextPC     fetch-phase PC increment
//   RegW       register-file write request
//   MemW       memory write request
//   NoWrite    compare-type instruction, no register write
//   PCWrite    gated PC enable
//   RegWrite   gated register-file enable
//   MemWrite   gated memory enable
//   CondEx     registered condition result
//   Flags      current {N,Z,C,V}
//   SkipCount  saturating count of condition-failed instructions
//
// Build option: COND_FLAG_BYPASS_EN evaluates the condition against the
// flags being written in the same cycle instead of the registered flags.

module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic             CondLatch,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] SkipCount
);

   logic [3:0]       flags_q;
   logic [3:0]       flags_d;
   logic [3:0]       eval;
   logic             condex_q;
   logic             cond_ok;
   logic [CNT_W-1:0] skip_q;
   logic             n, z, c, v;

   // Flag writes are qualified by the CondEx of the instruction in flight.
   always_comb begin
      flags_d = flags_q;
      if (FlagW[1] && condex_q)
         flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0] && condex_q)
         flags_d[1:0] = ALUFlags[1:0];
   end

`ifdef COND_FLAG_BYPASS_EN
   assign eval = flags_d;
`else
   assign eval = flags_q;
`endif

   assign n = eval[3];
   assign z = eval[2];
   assign c = eval[1];
   assign v = eval[0];

   always_comb begin
      cond_ok = 1'b1;
      unique case (Cond)
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = ~z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = ~c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = ~n;
         4'b0110: cond_ok = v;
         4'b0111: cond_ok = ~v;
         4'b1000: cond_ok = c & ~z;
         4'b1001: cond_ok = ~c | z;
         4'b1010: cond_ok = (n == v);
         4'b1011: cond_ok = (n != v);
         4'b1100: cond_ok = ~z & (n == v);
         4'b1101: cond_ok = z | (n != v);
         default: cond_ok = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
         skip_q   <= '0;
      end else begin
         flags_q <= flags_d;
         if (CondLatch) begin
            condex_q <= cond_ok;
            if (!cond_ok && (skip_q != {CNT_W{1'b1}}))
               skip_q <= skip_q + 1'b1;
         end
      end
   end

   assign PCWrite   = reset & ((PCS & condex_q) | NextPC);
   assign RegWrite  = reset & RegW & condex_q & ~NoWrite;
   assign MemWrite  = reset & MemW & condex_q;
   assign CondEx    = condex_q;
   assign Flags     = flags_q;
   assign SkipCount = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed stimulus with a queued-expectation scoreboard.
// Inputs change 1 time unit after each rising edge; checks run mid-cycle.

module tb_cond_unit;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic             CondLatch;
   logic [1:0]       FlagW;
   logic             PCS, NextPC, RegW, MemW, NoWrite;
   logic             PCWrite, RegWrite, MemWrite, CondEx;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] SkipCount;

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
      .CondLatch(CondLatch), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC),
      .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .SkipCount(SkipCount)
   );

   always #5 clk = ~clk;

   localparam int S_PCW = 0, S_RGW = 1, S_MEMW = 2;
   localparam int S_CEX = 3, S_FLG = 4, S_SKP = 5;

   typedef struct {
      int    cyc;
      int    sig;
      int    exp;
      string name;
   } chk_t;

   chk_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int sig, input int exp, input string name);
      q.push_back('{cyc, sig, exp, name});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick(input int sig);
      case (sig)
         S_PCW:   return {31'b0, PCWrite};
         S_RGW:   return {31'b0, RegWrite};
         S_MEMW:  return {31'b0, MemWrite};
         S_CEX:   return {31'b0, CondEx};
         S_FLG:   return {28'b0, Flags};
         default: return {16'b0, SkipCount};
      endcase
   endfunction

   // Monitor: pops every expectation due in the current cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         chk_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = pick(e.sig);
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
         end
      end
   end

   task automatic idle();
      CondLatch = 0; FlagW = 2'b00; PCS = 0; NextPC = 0;
      RegW = 0; MemW = 0; NoWrite = 0;
   endtask

   task automatic latch(input logic [3:0] c);
      tick(); idle();
      Cond = c; CondLatch = 1;
   endtask

   task automatic fwrite(input logic [1:0] fw, input logic [3:0] f);
      tick(); idle();
      FlagW = fw; ALUFlags = f;
   endtask

`ifdef COND_FLAG_BYPASS_EN
   localparam int SKIP_PRE = 6;
   localparam int BYP_CEX  = 1;
`else
   localparam int SKIP_PRE = 7;
   localparam int BYP_CEX  = 0;
`endif

   logic [3:0] sweep_c [4];
   int         exp_a   [4];
   int         exp_b   [4];

   initial begin
      sweep_c = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
      exp_a   = '{1, 0, 1, 0};
      exp_b   = '{0, 1, 0, 1};

      reset = 0; Cond = 4'b0000; ALUFlags = 4'b0000;
      idle();
      RegW = 1; MemW = 1; PCS = 1;

      tick();
      chk(S_PCW, 0, "rst_pcw1"); chk(S_RGW, 0, "rst_rgw1");
      chk(S_MEMW, 0, "rst_memw1");
      tick();
      chk(S_PCW, 0, "rst_pcw2"); chk(S_RGW, 0, "rst_rgw2");
      chk(S_MEMW, 0, "rst_memw2");
      chk(S_FLG, 0, "rst_flags"); chk(S_CEX, 0, "rst_condex");
      chk(S_SKP, 0, "rst_skip");

      // AL latch, then N,Z,C,V write of 0100
      tick(); reset = 1; idle(); Cond = 4'b1110; CondLatch = 1;
      fwrite(2'b11, 4'b0100); RegW = 1;
      chk(S_CEX, 1, "al_condex"); chk(S_RGW, 1, "al_regwrite");
      chk(S_FLG, 0, "flag_lat0");
      tick(); idle();
      chk(S_FLG, 4'b0100, "flags_0100");

      // NE with Z=1 fails
      latch(4'b0001);
      tick(); idle(); RegW = 1; MemW = 1; PCS = 1;
      chk(S_CEX, 0, "ne_condex"); chk(S_SKP, 1, "ne_skip");
      chk(S_PCW, 0, "ne_pcw"); chk(S_RGW, 0, "ne_rgw");
      chk(S_MEMW, 0, "ne_memw");
      tick(); NextPC = 1;
      chk(S_PCW, 1, "nextpc_pcw");

      // Flags 1001 sweep
      latch(4'b1110);
      fwrite(2'b11, 4'b1001);
      tick(); idle();
      chk(S_FLG, 4'b1001, "flags_1001");
      for (int i = 0; i < 4; i++) begin
         latch(sweep_c[i]);
         tick(); idle();
         chk(S_CEX, exp_a[i], $sformatf("nv11_c%0d", i));
      end

      // Flags 1000 sweep
      latch(4'b1110);
      fwrite(2'b11, 4'b1000);
      tick(); idle();
      chk(S_FLG, 4'b1000, "flags_1000");
      for (int i = 0; i < 4; i++) begin
         latch(sweep_c[i]);
         tick(); idle();
         chk(S_CEX, exp_b[i], $sformatf("nv10_c%0d", i));
      end
      chk(S_SKP, 5, "sweep_skip");

      // Flags 0000 with CondEx=1, then same-cycle EQ latch and Z write
      latch(4'b1110);
      fwrite(2'b11, 4'b0000);
      tick(); idle();
      chk(S_FLG, 0, "flags_0000"); chk(S_CEX, 1, "pre_byp_cex");
      ALUFlags = 4'b0100; FlagW = 2'b10; Cond = 4'b0000; CondLatch = 1;
      tick(); idle();
      chk(S_CEX, BYP_CEX, "bypass_eq");
      chk(S_FLG, 4'b0100, "bypass_flags");

      // Fail, then AL latch with a FlagW qualified by the old CondEx=0
      latch(4'b0001);
      tick(); idle();
      chk(S_CEX, 0, "old_cex0");
      FlagW = 2'b11; ALUFlags = 4'b1111; Cond = 4'b1110; CondLatch = 1;
      tick(); idle();
      chk(S_FLG, 4'b0100, "unqual_flags");
      chk(S_CEX, 1, "al_after_fail");
      chk(S_SKP, SKIP_PRE, "skip_pre");

      // C,V-only write; NoWrite suppression
      fwrite(2'b11, 4'b0000);
      fwrite(2'b01, 4'b1111);
      chk(S_FLG, 0, "flags_clr");
      tick(); idle(); RegW = 1; NoWrite = 1;
      chk(S_FLG, 4'b0011, "flags_cv_only");
      chk(S_RGW, 0, "nowrite_rgw");
      tick(); NoWrite = 0;
      chk(S_RGW, 1, "regw_cex1");

      // Saturation: EQ fails with Z=0
      tick(); idle(); Cond = 4'b0000; CondLatch = 1;
      for (int i = 1; i < 16'hFFFE - SKIP_PRE; i++) tick();
      tick(); idle();
      chk(S_SKP, 16'hFFFE, "skip_fffe");
      Cond = 4'b0000; CondLatch = 1;
      tick();
      chk(S_SKP, 16'hFFFF, "skip_ffff");
      tick();
      chk(S_SKP, 16'hFFFF, "skip_hold1");
      tick(); idle();
      chk(S_SKP, 16'hFFFF, "skip_hold2");

      // Reset mid-instruction drops a pending CondEx=1
      latch(4'b1110);
      tick(); idle();
      chk(S_CEX, 1, "pre_rst_cex");
      reset = 0;
      tick(); reset = 1; RegW = 1; MemW = 1;
      chk(S_RGW, 0, "post_rst_rgw"); chk(S_MEMW, 0, "post_rst_memw");
      chk(S_CEX, 0, "post_rst_cex"); chk(S_SKP, 0, "post_rst_skip");
      chk(S_FLG, 0, "post_rst_flags");

      tick(); idle();
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
